// File: rtl/ex_stage_pkg.sv
// ============================================================================
// Module      : ex_stage_pkg
// Description : Shared widths, ALU operation codes, operand-form codes, the
//               EX/MEM register record and a forwarding-match helper for the
//               execute stage.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ex_stage_pkg;

  localparam int WORD_WIDTH        = 32;
  localparam int DATA_WIDTH_ALU_OP = 5;
  localparam int REG_ADDR_WIDTH    = 5;

  // ALU operation codes. R-type ops take (rs1, rs2) on (in_0, in_1);
  // I-type ops take (imm, rs1) on (in_0, in_1).
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_ADD   = 5'd0;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_SUB   = 5'd1;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_SLL   = 5'd2;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_SLT   = 5'd3;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_SLTU  = 5'd4;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_XOR   = 5'd5;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_SRL   = 5'd6;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_SRA   = 5'd7;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_OR    = 5'd8;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_AND   = 5'd9;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_ADDI  = 5'd10;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_SLTI  = 5'd11;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_SLTIU = 5'd12;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_XORI  = 5'd13;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_ORI   = 5'd14;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_ANDI  = 5'd15;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_SLLI  = 5'd16;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_SRLI  = 5'd17;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_SRAI  = 5'd18;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_LUI   = 5'd19;
  localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_AUIPC = 5'd20;

  // Operand forms presented by decode.
  localparam logic [1:0] OP_TYPE_R     = 2'd0;
  localparam logic [1:0] OP_TYPE_I     = 2'd1;
  localparam logic [1:0] OP_TYPE_LUI   = 2'd2;
  localparam logic [1:0] OP_TYPE_AUIPC = 2'd3;

  // Contents of the EX/MEM pipeline register.
  typedef struct packed {
    logic                      valid;
    logic [WORD_WIDTH-1:0]     alu_out;
    logic [WORD_WIDTH-1:0]     store_data;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic                      rd_we;
    logic                      is_load;
    logic                      is_store;
  } ex_mem_t;

  // A producer matches a source when it is enabled, targets the same
  // register, and that register is not x0 (x0 is never forwarded).
  function automatic logic reg_match(input logic                      en,
                                     input logic [REG_ADDR_WIDTH-1:0] rd,
                                     input logic [REG_ADDR_WIDTH-1:0] rs);
    return en && (rd != '0) && (rd == rs);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_stage_if.sv
// ============================================================================
// Module      : ex_stage_if
// Description : Bundle of ID/EX inputs, writeback/control inputs and EX/MEM
//               outputs of the execute stage.
// Modports    : master - pipeline side (drives id_*, wb_*, mem_stall,
//                        ex_flush; observes load_use_stall and ex_*)
//               slave  - execute stage
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ex_stage_if;
  import ex_stage_pkg::*;

  logic                         id_valid;
  logic [DATA_WIDTH_ALU_OP-1:0] id_alu_op;
  logic [1:0]                   id_op_type;
  logic [REG_ADDR_WIDTH-1:0]    id_rs1_addr;
  logic [REG_ADDR_WIDTH-1:0]    id_rs2_addr;
  logic                         id_rs1_used;
  logic                         id_rs2_used;
  logic [WORD_WIDTH-1:0]        id_rs1_data;
  logic [WORD_WIDTH-1:0]        id_rs2_data;
  logic [WORD_WIDTH-1:0]        id_imm;
  logic [WORD_WIDTH-1:0]        id_pc;
  logic [REG_ADDR_WIDTH-1:0]    id_rd_addr;
  logic                         id_rd_we;
  logic                         id_is_load;
  logic                         id_is_store;

  logic                         wb_rd_we;
  logic [REG_ADDR_WIDTH-1:0]    wb_rd_addr;
  logic [WORD_WIDTH-1:0]        wb_rd_data;

  logic                         mem_stall;
  logic                         ex_flush;

  logic                         load_use_stall;
  logic                         ex_valid;
  logic [WORD_WIDTH-1:0]        ex_alu_out;
  logic [WORD_WIDTH-1:0]        ex_store_data;
  logic [REG_ADDR_WIDTH-1:0]    ex_rd_addr;
  logic                         ex_rd_we;
  logic                         ex_is_load;
  logic                         ex_is_store;

  modport master (
    output id_valid, id_alu_op, id_op_type, id_rs1_addr, id_rs2_addr,
           id_rs1_used, id_rs2_used, id_rs1_data, id_rs2_data, id_imm,
           id_pc, id_rd_addr, id_rd_we, id_is_load, id_is_store,
           wb_rd_we, wb_rd_addr, wb_rd_data, mem_stall, ex_flush,
    input  load_use_stall, ex_valid, ex_alu_out, ex_store_data,
           ex_rd_addr, ex_rd_we, ex_is_load, ex_is_store
  );

  modport slave (
    input  id_valid, id_alu_op, id_op_type, id_rs1_addr, id_rs2_addr,
           id_rs1_used, id_rs2_used, id_rs1_data, id_rs2_data, id_imm,
           id_pc, id_rd_addr, id_rd_we, id_is_load, id_is_store,
           wb_rd_we, wb_rd_addr, wb_rd_data, mem_stall, ex_flush,
    output load_use_stall, ex_valid, ex_alu_out, ex_store_data,
           ex_rd_addr, ex_rd_we, ex_is_load, ex_is_store
  );

endinterface

`default_nettype wire

// File: rtl/ex_stage_alu.sv
// ============================================================================
// Module      : ex_stage_alu
// Description : Combinational integer ALU. Arithmetic wraps modulo 2^32.
// Ports       : alu_op  in  operation code
//               in_0    in  R-type: rs1      | I/LUI/AUIPC: immediate
//               in_1    in  R-type: rs2      | I: rs1 | AUIPC: pc | LUI: 0
//               out     out result
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_stage_alu
  import ex_stage_pkg::*;
(
  input  logic [DATA_WIDTH_ALU_OP-1:0] alu_op,
  input  logic [WORD_WIDTH-1:0]        in_0,
  input  logic [WORD_WIDTH-1:0]        in_1,
  output logic [WORD_WIDTH-1:0]        out
);

  // U-type immediates arrive right-aligned; the shift into place lives here.
  logic [WORD_WIDTH-1:0] w_upper;
  assign w_upper = in_0 << 12;

  always_comb begin
    out = '0;
    case (alu_op)
      ALU_OP_ADD:   out = in_0 + in_1;
      ALU_OP_SUB:   out = in_0 - in_1;
      ALU_OP_SLL:   out = in_0 << in_1[4:0];
      ALU_OP_SLT:   out = {31'd0, $signed(in_0) < $signed(in_1)};
      ALU_OP_SLTU:  out = {31'd0, in_0 < in_1};
      ALU_OP_XOR:   out = in_0 ^ in_1;
      ALU_OP_SRL:   out = in_0 >> in_1[4:0];
      ALU_OP_SRA:   out = $unsigned($signed(in_0) >>> in_1[4:0]);
      ALU_OP_OR:    out = in_0 | in_1;
      ALU_OP_AND:   out = in_0 & in_1;
      // Immediate forms: operand order is swapped (imm on in_0, rs1 on in_1).
      ALU_OP_ADDI:  out = in_1 + in_0;
      ALU_OP_SLTI:  out = {31'd0, $signed(in_1) < $signed(in_0)};
      ALU_OP_SLTIU: out = {31'd0, in_1 < in_0};
      ALU_OP_XORI:  out = in_1 ^ in_0;
      ALU_OP_ORI:   out = in_1 | in_0;
      ALU_OP_ANDI:  out = in_1 & in_0;
      ALU_OP_SLLI:  out = in_1 << in_0[4:0];
      ALU_OP_SRLI:  out = in_1 >> in_0[4:0];
      ALU_OP_SRAI:  out = $unsigned($signed(in_1) >>> in_0[4:0]);
      ALU_OP_LUI:   out = w_upper;
      ALU_OP_AUIPC: out = w_upper + in_1;
      default:      out = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ex_stage.sv
// ============================================================================
// Module      : ex_stage
// Description : Pipeline execute stage. Forwards operands from EX/MEM and WB,
//               selects ALU operands by instruction form, detects load-use
//               hazards and registers results into the EX/MEM register.
// Ports       : clk  in   pipeline clock
//               rst  in   synchronous active-high reset
//               bus  slave modport of ex_stage_if:
//                    id_*            ID/EX instruction fields
//                    wb_*            writeback forwarding source
//                    mem_stall       hold EX/MEM
//                    ex_flush        kill instruction entering EX/MEM
//                    load_use_stall  combinational upstream hold request
//                    ex_*            registered EX/MEM outputs
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_stage
  import ex_stage_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  ex_stage_if.slave bus
);

  ex_mem_t               r_ex;

  logic                  w_ex_fwd_en;
  logic [WORD_WIDTH-1:0] w_fwd_rs1;
  logic [WORD_WIDTH-1:0] w_fwd_rs2;
  logic [WORD_WIDTH-1:0] w_alu_in_0;
  logic [WORD_WIDTH-1:0] w_alu_in_1;
  logic [WORD_WIDTH-1:0] w_alu_out;
  logic                  w_load_use;

  // A load's EX/MEM value is an address, not the loaded data, so loads are
  // excluded from EX/MEM forwarding; the hazard logic covers that case.
  assign w_ex_fwd_en = r_ex.valid & r_ex.rd_we & ~r_ex.is_load;

  always_comb begin
    w_fwd_rs1 = bus.id_rs1_data;
    if (reg_match(w_ex_fwd_en, r_ex.rd_addr, bus.id_rs1_addr))
      w_fwd_rs1 = r_ex.alu_out;
    else if (reg_match(bus.wb_rd_we, bus.wb_rd_addr, bus.id_rs1_addr))
      w_fwd_rs1 = bus.wb_rd_data;
  end

  always_comb begin
    w_fwd_rs2 = bus.id_rs2_data;
    if (reg_match(w_ex_fwd_en, r_ex.rd_addr, bus.id_rs2_addr))
      w_fwd_rs2 = r_ex.alu_out;
    else if (reg_match(bus.wb_rd_we, bus.wb_rd_addr, bus.id_rs2_addr))
      w_fwd_rs2 = bus.wb_rd_data;
  end

  always_comb begin
    w_alu_in_0 = bus.id_imm;
    w_alu_in_1 = '0;
    case (bus.id_op_type)
      OP_TYPE_R: begin
        w_alu_in_0 = w_fwd_rs1;
        w_alu_in_1 = w_fwd_rs2;
      end
      OP_TYPE_I:     w_alu_in_1 = w_fwd_rs1;
      OP_TYPE_LUI:   w_alu_in_1 = '0;
      OP_TYPE_AUIPC: w_alu_in_1 = bus.id_pc;
      default:       w_alu_in_1 = '0;
    endcase
  end

  ex_stage_alu u_alu (
    .alu_op (bus.id_alu_op),
    .in_0   (w_alu_in_0),
    .in_1   (w_alu_in_1),
    .out    (w_alu_out)
  );

  // Only sources the instruction really reads can create a hazard.
  assign w_load_use = r_ex.valid & r_ex.is_load & r_ex.rd_we &
                      (r_ex.rd_addr != '0) & bus.id_valid &
                      ((bus.id_rs1_used & (r_ex.rd_addr == bus.id_rs1_addr)) |
                       (bus.id_rs2_used & (r_ex.rd_addr == bus.id_rs2_addr)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex <= '0;
    end else if (bus.mem_stall) begin
      // Hold everything; a flush arriving now is dropped and must be
      // re-asserted once the stall clears.
      r_ex <= r_ex;
    end else if (bus.ex_flush || w_load_use) begin
      // Bubble: data fields are left as-is since nothing downstream uses them.
      r_ex.valid    <= 1'b0;
      r_ex.rd_we    <= 1'b0;
      r_ex.is_load  <= 1'b0;
      r_ex.is_store <= 1'b0;
    end else begin
      r_ex.valid      <= bus.id_valid;
      r_ex.alu_out    <= w_alu_out;
      r_ex.store_data <= w_fwd_rs2;
      r_ex.rd_addr    <= bus.id_rd_addr;
      r_ex.rd_we      <= bus.id_rd_we    & bus.id_valid;
      r_ex.is_load    <= bus.id_is_load  & bus.id_valid;
      r_ex.is_store   <= bus.id_is_store & bus.id_valid;
    end
  end

  assign bus.load_use_stall = w_load_use;
  assign bus.ex_valid       = r_ex.valid;
  assign bus.ex_alu_out     = r_ex.alu_out;
  assign bus.ex_store_data  = r_ex.store_data;
  assign bus.ex_rd_addr     = r_ex.rd_addr;
  assign bus.ex_rd_we       = r_ex.rd_we;
  assign bus.ex_is_load     = r_ex.is_load;
  assign bus.ex_is_store    = r_ex.is_store;

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
// ============================================================================
// Module      : tb_ex_stage
// Description : Directed self-checking bench for ex_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_stage;
  import ex_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ex_stage_if bus ();

  ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [4:0] op, input logic [1:0] ty,
                       input logic [4:0] rs1, input logic u1, input logic [31:0] d1,
                       input logic [4:0] rs2, input logic u2, input logic [31:0] d2,
                       input logic [31:0] imm, input logic [31:0] pc,
                       input logic [4:0] rd, input logic we, input logic ld, input logic st);
    bus.id_valid    = v;
    bus.id_alu_op   = op;
    bus.id_op_type  = ty;
    bus.id_rs1_addr = rs1;
    bus.id_rs1_used = u1;
    bus.id_rs1_data = d1;
    bus.id_rs2_addr = rs2;
    bus.id_rs2_used = u2;
    bus.id_rs2_data = d2;
    bus.id_imm      = imm;
    bus.id_pc       = pc;
    bus.id_rd_addr  = rd;
    bus.id_rd_we    = we;
    bus.id_is_load  = ld;
    bus.id_is_store = st;
  endtask

  task automatic wb(input logic we, input logic [4:0] addr, input logic [31:0] data);
    bus.wb_rd_we   = we;
    bus.wb_rd_addr = addr;
    bus.wb_rd_data = data;
  endtask

  initial begin
    rst           = 1'b1;
    bus.mem_stall = 1'b0;
    bus.ex_flush  = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    // ADDI x1,x0,5 presented during reset
    issue(1, ALU_OP_ADDI, OP_TYPE_I, 5'd0, 1, 32'h0, 5'd0, 0, 32'h0, 32'd5, 32'h0, 5'd1, 1, 0, 0);
    tick();
    tick();
    check("rst_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("rst_alu_out", bus.ex_alu_out, 32'd0);
    check("rst_rd_addr", {27'd0, bus.ex_rd_addr}, 32'd0);
    check("rst_rd_we", {31'd0, bus.ex_rd_we}, 32'd0);
    check("rst_store_data", bus.ex_store_data, 32'd0);
    check("rst_lu_stall", {31'd0, bus.load_use_stall}, 32'd0);

    rst = 1'b0;
    tick();
    check("addi_alu_out", bus.ex_alu_out, 32'd5);
    check("addi_rd_addr", {27'd0, bus.ex_rd_addr}, 32'd1);
    check("addi_valid", {31'd0, bus.ex_valid}, 32'd1);

    // Invalid slot: flags must be masked by id_valid
    issue(0, ALU_OP_ADD, OP_TYPE_R, 5'd1, 1, 32'h0, 5'd2, 1, 32'h0, 32'h0, 32'h0, 5'd3, 1, 1, 1);
    tick();
    check("bubble_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("bubble_rd_we", {31'd0, bus.ex_rd_we}, 32'd0);
    check("bubble_is_load", {31'd0, bus.ex_is_load}, 32'd0);

    // ADD x3,x1,x2 (7+9) then SUB x4,x3,x1 with stale rs1 data
    issue(1, ALU_OP_ADD, OP_TYPE_R, 5'd1, 1, 32'd7, 5'd2, 1, 32'd9, 32'h0, 32'h0, 5'd3, 1, 0, 0);
    tick();
    check("add_x3", bus.ex_alu_out, 32'd16);
    issue(1, ALU_OP_SUB, OP_TYPE_R, 5'd3, 1, 32'd0, 5'd1, 1, 32'd7, 32'h0, 32'h0, 5'd4, 1, 0, 0);
    tick();
    check("sub_exmem_fwd", bus.ex_alu_out, 32'd9);

    // Write to x0 must never be forwarded, from EX/MEM or WB
    issue(1, ALU_OP_ADDI, OP_TYPE_I, 5'd0, 1, 32'h0, 5'd0, 0, 32'h0, 32'h55, 32'h0, 5'd0, 1, 0, 0);
    tick();
    check("x0_write_out", bus.ex_alu_out, 32'h55);
    issue(1, ALU_OP_ADD, OP_TYPE_R, 5'd0, 1, 32'h0, 5'd0, 1, 32'h0, 32'h0, 32'h0, 5'd8, 1, 0, 0);
    wb(1'b1, 5'd0, 32'h99);
    tick();
    check("x0_no_fwd", bus.ex_alu_out, 32'd0);
    wb(1'b0, 5'd0, 32'h0);

    // Priority: EX/MEM x5 = 0x10 beats WB x5 = 0x20
    issue(1, ALU_OP_ADDI, OP_TYPE_I, 5'd0, 1, 32'h0, 5'd0, 0, 32'h0, 32'h10, 32'h0, 5'd5, 1, 0, 0);
    tick();
    issue(1, ALU_OP_ADD, OP_TYPE_R, 5'd5, 1, 32'h0, 5'd0, 1, 32'h0, 32'h0, 32'h0, 5'd9, 1, 0, 0);
    wb(1'b1, 5'd5, 32'h20);
    tick();
    check("fwd_priority", bus.ex_alu_out, 32'h10);
    // WB-only forward on rs2
    issue(1, ALU_OP_ADD, OP_TYPE_R, 5'd0, 1, 32'h0, 5'd5, 1, 32'h0, 32'h0, 32'h0, 5'd10, 1, 0, 0);
    tick();
    check("wb_fwd_rs2", bus.ex_alu_out, 32'h20);
    check("wb_fwd_store_data", bus.ex_store_data, 32'h20);
    wb(1'b0, 5'd0, 32'h0);

    // Load-use: LW x6,0x40(x0) then ADD x7,x6,x6
    issue(1, ALU_OP_ADDI, OP_TYPE_I, 5'd0, 1, 32'h0, 5'd0, 0, 32'h0, 32'h40, 32'h0, 5'd6, 1, 1, 0);
    tick();
    check("lw_addr", bus.ex_alu_out, 32'h40);
    check("lw_is_load", {31'd0, bus.ex_is_load}, 32'd1);
    issue(1, ALU_OP_ADD, OP_TYPE_R, 5'd6, 1, 32'h0, 5'd6, 1, 32'h0, 32'h0, 32'h0, 5'd7, 1, 0, 0);
    #1;
    check("lu_stall_on", {31'd0, bus.load_use_stall}, 32'd1);
    tick();
    check("lu_bubble_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("lu_stall_off", {31'd0, bus.load_use_stall}, 32'd0);
    wb(1'b1, 5'd6, 32'h44);
    tick();
    check("lu_add_result", bus.ex_alu_out, 32'h88);
    check("lu_add_valid", {31'd0, bus.ex_valid}, 32'd1);
    check("lu_add_rd", {27'd0, bus.ex_rd_addr}, 32'd7);
    wb(1'b0, 5'd0, 32'h0);

    // mem_stall for 3 cycles freezes EX/MEM
    bus.mem_stall = 1'b1;
    issue(1, ALU_OP_ADDI, OP_TYPE_I, 5'd0, 1, 32'h0, 5'd0, 0, 32'h0, 32'd1, 32'h0, 5'd11, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_alu_out", bus.ex_alu_out, 32'h88);
      check("stall_rd_addr", {27'd0, bus.ex_rd_addr}, 32'd7);
    end
    // Flush during stall is ignored
    bus.ex_flush = 1'b1;
    tick();
    check("stall_flush_valid", {31'd0, bus.ex_valid}, 32'd1);
    check("stall_flush_rd_we", {31'd0, bus.ex_rd_we}, 32'd1);
    // Flush without stall kills the entry
    bus.mem_stall = 1'b0;
    tick();
    check("flush_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("flush_rd_we", {31'd0, bus.ex_rd_we}, 32'd0);
    bus.ex_flush = 1'b0;
    tick();
    check("after_flush_out", bus.ex_alu_out, 32'd1);
    check("after_flush_valid", {31'd0, bus.ex_valid}, 32'd1);

    // SUB x12,x0,x11 with x11 forwarded (=1) -> wraps to all ones
    issue(1, ALU_OP_SUB, OP_TYPE_R, 5'd0, 1, 32'h0, 5'd11, 1, 32'h0, 32'h0, 32'h0, 5'd12, 1, 0, 0);
    tick();
    check("sub_wrap", bus.ex_alu_out, 32'hFFFF_FFFF);

    // SRAI x13,x20,4
    issue(1, ALU_OP_SRAI, OP_TYPE_I, 5'd20, 1, 32'h8000_0000, 5'd0, 0, 32'h0, 32'd4, 32'h0, 5'd13, 1, 0, 0);
    tick();
    check("srai", bus.ex_alu_out, 32'hF800_0000);

    // LUI / AUIPC
    issue(1, ALU_OP_LUI, OP_TYPE_LUI, 5'd0, 0, 32'h0, 5'd0, 0, 32'h0, 32'h12345, 32'h0, 5'd14, 1, 0, 0);
    tick();
    check("lui", bus.ex_alu_out, 32'h1234_5000);
    issue(1, ALU_OP_AUIPC, OP_TYPE_AUIPC, 5'd0, 0, 32'h0, 5'd0, 0, 32'h0, 32'h12345, 32'h100, 5'd15, 1, 0, 0);
    tick();
    check("auipc", bus.ex_alu_out, 32'h1234_5100);

    // SW x17,8(x16)
    issue(1, ALU_OP_ADDI, OP_TYPE_I, 5'd16, 1, 32'h100, 5'd17, 1, 32'hDEAD_BEEF, 32'd8, 32'h0, 5'd0, 0, 0, 1);
    tick();
    check("sw_addr", bus.ex_alu_out, 32'h108);
    check("sw_data", bus.ex_store_data, 32'hDEAD_BEEF);
    check("sw_is_store", {31'd0, bus.ex_is_store}, 32'd1);
    check("sw_rd_we", {31'd0, bus.ex_rd_we}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the siiCpu pipeline. Sits between the ID/EX boundary and the memory stage.
- Selects ALU operands, applying EX/MEM and WB forwarding, and drives an internal alu instance.
- Detects load-use hazards and registers the result into the EX/MEM pipeline register, with stall and flush support.

Parameters:
- None. Widths come from shared macros: WORD_WIDTH = 32; DATA_WIDTH_ALU_OP; REG_ADDR_WIDTH = 5.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID/EX slot holds a real instruction
- id_alu_op  in  DATA_WIDTH_ALU_OP  ALU operation code
- id_op_type  in  2  operand form: 0 = R-type, 1 = I-type, 2 = LUI, 3 = AUIPC
- id_rs1_addr, id_rs2_addr  in  5  source register indices
- id_rs1_used, id_rs2_used  in  1  the source is actually read by this instruction
- id_rs1_data, id_rs2_data  in  32  register-file read data
- id_imm  in  32  immediate; U-type carries the raw 20-bit field, right-aligned
- id_pc  in  32  instruction PC
- id_rd_addr  in  5  destination index
- id_rd_we  in  1  writes rd
- id_is_load, id_is_store  in  1  memory-op flags
- wb_rd_we  in  1  writeback enable
- wb_rd_addr  in  5  writeback destination
- wb_rd_data  in  32  writeback data
- mem_stall  in  1  memory stage cannot accept; hold EX/MEM
- ex_flush  in  1  kill the instruction entering EX/MEM (branch redirect, trap)
- load_use_stall  out  1  combinational; upstream must hold IF/ID and ID/EX
- ex_valid  out  1  EX/MEM valid
- ex_alu_out  out  32  registered ALU result (memory address for load/store)
- ex_store_data  out  32  registered forwarded rs2
- ex_rd_addr  out  5  registered rd
- ex_rd_we  out  1  registered rd write enable
- ex_is_load, ex_is_store  out  1  registered memory flags

Behaviour:
- Reset: on rst high at the clk edge, all registered outputs go to 0. load_use_stall is 0 while ex_valid = 0.
- Forwarding, per source (rs1 and rs2 independently), in priority order:
  - (a) EX/MEM: ex_valid & ex_rd_we & !ex_is_load & ex_rd_addr != 0 & ex_rd_addr == rsN → ex_alu_out.
  - (b) WB: wb_rd_we & wb_rd_addr != 0 & wb_rd_addr == rsN → wb_rd_data.
  - (c) Otherwise id_rsN_data.
  - x0 is never forwarded.
- Operand convention for the alu:
  - R-type: alu_in_0 = fwd_rs1, alu_in_1 = fwd_rs2.
  - I-type (incl. SLTI, SLTIU, shifts): alu_in_0 = id_imm, alu_in_1 = fwd_rs1. Shift amount = id_imm[4:0].
  - LUI: alu_in_0 = id_imm, alu_in_1 = 0. The alu applies the <<12.
  - AUIPC: alu_in_0 = id_imm, alu_in_1 = id_pc.
  - Load/store address: I-type with ALU_OP_ADDI.
- Load-use hazard: load_use_stall = ex_valid & ex_is_load & ex_rd_we & ex_rd_addr != 0 & id_valid & ((id_rs1_used & rs1 match) | (id_rs2_used & rs2 match)).
- EX/MEM register update, priority highest first:
  - rst.
  - mem_stall: hold all outputs, including load_use_stall evaluation. Stall wins over flush; the flush must be re-asserted by the requester.
  - ex_flush: ex_valid ← 0, ex_rd_we ← 0, ex_is_load ← 0, ex_is_store ← 0. Data fields are don't-care.
  - load_use_stall: insert a bubble (same as flush); ID/EX is held upstream.
  - Otherwise: capture. ex_valid ← id_valid; control flags are ANDed with id_valid.
- Latency: 1 cycle, ID/EX to EX/MEM. A load followed by a dependent instruction costs exactly 1 bubble; the dependent value then arrives via WB forwarding.
- 32-bit arithmetic wraps modulo 2^32; no overflow flag.

Decomposition:
- Shared define file (existing): WORD_WIDTH, DATA_WIDTH_ALU_OP, ALU_OP_* codes, and new OP_TYPE_R, OP_TYPE_I, OP_TYPE_LUI, OP_TYPE_AUIPC constants.
- One sub-module: the existing alu, instantiated unchanged.
- Forwarding mux and hazard detect stay inline.

Test Plan:
- Reset: rst = 1 for 2 cycles with id_valid = 1 → all outputs 0; after release, ADDI x1,x0,5 → ex_alu_out = 5, ex_rd_addr = 1, ex_valid = 1 next cycle.
- Back-to-back dependency: ADD x3,x1,x2 (x1 = 7, x2 = 9 in regfile) then SUB x4,x3,x1 with stale id_rs1_data = 0 → second ex_alu_out = 16 − 7 = 9 via EX/MEM forward. Forward from x0 as rd is never taken.
- Priority: EX/MEM and WB both target x5, with values 0x10 and 0x20 → EX/MEM value 0x10 is used.
- Load-use: LW x6 in EX, next ADD x7,x6,x6 → load_use_stall = 1 for exactly 1 cycle, one ex_valid = 0 bubble, then ADD completes using wb_rd_data = 0x44 → 0x88.
- Stall/flush: mem_stall held 3 cycles → outputs frozen; ex_flush with mem_stall = 0 → ex_valid = 0, ex_rd_we = 0 next cycle. ex_flush during mem_stall → ignored.
- LUI/AUIPC: id_imm = 0x12345 → LUI ex_alu_out = 0x12345000; AUIPC with pc = 0x100 → 0x12345100.
